display_control_sequencer: RTL and testbench

//  Fetches and executes MCD212 display control programs:
//   - ICA: once per field, starting at ICA_START.
//   - DCA: once per active line, from the DCA pointer.

---
 rtl/display_control_pkg.sv | 53 +++++
 rtl/dcp_instr_decode.sv | 38 +++
 rtl/display_control_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_display_control_sequencer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_control_pkg.sv
// Shared definitions for the MCD212 display control sequencer.
// Holds the state encoding, the opcode classes, default addresses and a
// few commonly used display register numbers.
package display_control_pkg;

  localparam int ADDR_W     = 23;
  localparam int REG_ADDR_W = 7;
  localparam int REG_DATA_W = 24;
  localparam int PARAM_W    = 5;

  localparam logic [ADDR_W-1:0] ICA_START_DEFAULT = 23'h000400;
  localparam int                DCA_WORDS_DEFAULT = 16;

  // Sequencer state encoding; kept as plain constants so checkers and
  // older code can compare against raw values.
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ICA_FETCH = 3'd1;
  localparam logic [2:0] ST_ICA_EXEC  = 3'd2;
  localparam logic [2:0] ST_WAIT_LINE = 3'd3;
  localparam logic [2:0] ST_DCA_FETCH = 3'd4;
  localparam logic [2:0] ST_DCA_EXEC  = 3'd5;
  localparam logic [2:0] ST_DRAIN     = 3'd6;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    ICA_FETCH = ST_ICA_FETCH,
    ICA_EXEC  = ST_ICA_EXEC,
    WAIT_LINE = ST_WAIT_LINE,
    DCA_FETCH = ST_DCA_FETCH,
    DCA_EXEC  = ST_DCA_EXEC,
    DRAIN     = ST_DRAIN
  } seq_state_e;

  // Opcodes 8..F all mean "register write"; they collapse onto OP_REG_WRITE.
  typedef enum logic [3:0] {
    OP_STOP       = 4'h0,
    OP_NOP        = 4'h1,
    OP_LD_DCP     = 4'h2,
    OP_LD_DCP_STP = 4'h3,
    OP_LD_ICA     = 4'h4,
    OP_LD_VSR_STP = 4'h5,
    OP_IRQ        = 4'h6,
    OP_PARAMS     = 4'h7,
    OP_REG_WRITE  = 4'h8
  } opcode_e;

  // Frequently written display registers.
  localparam logic [REG_ADDR_W-1:0] REG_IMAGE_CODING = 7'h40;
  localparam logic [REG_ADDR_W-1:0] REG_CLUT_BANK    = 7'h43;
  localparam logic [REG_ADDR_W-1:0] REG_TRANSPARENCY = 7'h47;
  localparam logic [REG_ADDR_W-1:0] REG_BACKDROP     = 7'h58;

endpackage

// File: rtl/dcp_instr_decode.sv
// Combinational decode of one 32-bit display control instruction.
// Ports:
//   instr_i        instruction word
//   opcode_o       opcode class (8..F folded to OP_REG_WRITE)
//   is_stop_o      instruction ends the current program
//   is_reg_write_o instr[31] set
//   reg_addr_o     register number instr[30:24]
//   reg_data_o     register value  instr[23:0]
//   ptr_o          word-aligned pointer {instr[22:2], 2'b00}
//   vsr_o          half-word-aligned VSR {instr[22:1], 1'b0}
//   params_o       display parameters instr[4:0]
module dcp_instr_decode
  import display_control_pkg::*;
(
  input  logic [31:0]           instr_i,
  output opcode_e               opcode_o,
  output logic                  is_stop_o,
  output logic                  is_reg_write_o,
  output logic [REG_ADDR_W-1:0] reg_addr_o,
  output logic [REG_DATA_W-1:0] reg_data_o,
  output logic [ADDR_W-1:0]     ptr_o,
  output logic [ADDR_W-1:0]     vsr_o,
  output logic [PARAM_W-1:0]    params_o
);

  always_comb begin
    is_reg_write_o = instr_i[31];
    opcode_o       = instr_i[31] ? OP_REG_WRITE : opcode_e'(instr_i[31:28]);
    is_stop_o      = (opcode_o == OP_STOP) || (opcode_o == OP_LD_DCP_STP) ||
                     (opcode_o == OP_LD_VSR_STP);
    reg_addr_o     = instr_i[30:24];
    reg_data_o     = instr_i[23:0];
    ptr_o          = {instr_i[22:2], 2'b00};
    vsr_o          = {instr_i[22:1], 1'b0};
    params_o       = instr_i[4:0];
  end

endmodule

// File: rtl/display_control_sequencer.sv
// Fetches and executes MCD212 display control programs: the ICA once per
// field from ICA_START, the DCA once per active line from the DCA pointer.
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   field_start, line_start   strobes from video_timing
//   dca_enable                run DCA on line_start when 1
//   mem_req/mem_addr          instruction read request and byte address
//   mem_ack/mem_data          read completion with data in the same cycle
//   reg_we/reg_addr/reg_data  1-cycle display register write
//   vsr_ptr, disp_params      pixel path parameters
//   irq                       1-cycle interrupt pulse
//   busy                      high while an ICA/DCA program is running
//   dbg_state                 current sequencer state (seq_state_e encoding)
//
// Memory handshake: mem_req is the valid, mem_ack the ready. While mem_req
// is high, mem_addr is held; the transfer completes in the cycle both are
// high. mem_req is low in the cycle after every completion, and a raised
// request is only ever dropped by a completion or by reset.
module display_control_sequencer
  import display_control_pkg::*;
#(
  parameter logic [ADDR_W-1:0] ICA_START = ICA_START_DEFAULT,
  parameter int                DCA_WORDS = DCA_WORDS_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  field_start,
  input  logic                  line_start,
  input  logic                  dca_enable,
  output logic                  mem_req,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_data,
  output logic                  reg_we,
  output logic [REG_ADDR_W-1:0] reg_addr,
  output logic [REG_DATA_W-1:0] reg_data,
  output logic [ADDR_W-1:0]     vsr_ptr,
  output logic [PARAM_W-1:0]    disp_params,
  output logic                  irq,
  output logic                  busy,
  output logic [2:0]            dbg_state
);

  localparam int              CNT_W     = $clog2(DCA_WORDS + 1);
  localparam logic [CNT_W-1:0] DCA_LIMIT = CNT_W'(DCA_WORDS);

  logic [2:0]            state_q, state_d;
  logic [ADDR_W-1:0]     ica_ptr_q, ica_ptr_d;
  logic [ADDR_W-1:0]     dca_ptr_q, dca_ptr_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [CNT_W-1:0]      dca_cnt_q, dca_cnt_d;
  logic                  stop_q, stop_d;
  logic                  req_gap_q, req_gap_d;
  logic                  reg_we_q, reg_we_d;
  logic [REG_ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [REG_DATA_W-1:0] reg_data_q, reg_data_d;
  logic [ADDR_W-1:0]     vsr_q, vsr_d;
  logic [PARAM_W-1:0]    params_q, params_d;
  logic                  irq_q, irq_d;

  opcode_e               dec_op;
  logic                  dec_stop;
  logic                  dec_reg_write;
  logic [REG_ADDR_W-1:0] dec_reg_addr;
  logic [REG_DATA_W-1:0] dec_reg_data;
  logic [ADDR_W-1:0]     dec_ptr;
  logic [ADDR_W-1:0]     dec_vsr;
  logic [PARAM_W-1:0]    dec_params;
  logic                  fetching;
  logic                  ack_v;

  dcp_instr_decode u_decode (
    .instr_i        (mem_data),
    .opcode_o       (dec_op),
    .is_stop_o      (dec_stop),
    .is_reg_write_o (dec_reg_write),
    .reg_addr_o     (dec_reg_addr),
    .reg_data_o     (dec_reg_data),
    .ptr_o          (dec_ptr),
    .vsr_o          (dec_vsr),
    .params_o       (dec_params)
  );

  // req_gap_q covers a fetch entered straight from a completion (DRAIN, or
  // field_start coinciding with mem_ack): request stays low for that cycle.
  assign fetching = (state_q == ST_ICA_FETCH) || (state_q == ST_DCA_FETCH) ||
                    (state_q == ST_DRAIN);
  assign mem_req  = fetching && !req_gap_q;
  assign ack_v    = mem_ack && mem_req;

  always_comb begin
    state_d    = state_q;
    ica_ptr_d  = ica_ptr_q;
    dca_ptr_d  = dca_ptr_q;
    addr_d     = addr_q;
    dca_cnt_d  = dca_cnt_q;
    stop_d     = stop_q;
    req_gap_d  = 1'b0;
    reg_we_d   = 1'b0;
    irq_d      = 1'b0;
    reg_addr_d = reg_addr_q;
    reg_data_d = reg_data_q;
    vsr_d      = vsr_q;
    params_d   = params_q;
    case (state_q)
      ST_IDLE, ST_WAIT_LINE: begin
        if (field_start) begin
          state_d   = ST_ICA_FETCH;
          ica_ptr_d = ICA_START;
          addr_d    = ICA_START;
        end else if ((state_q == ST_WAIT_LINE) && line_start && dca_enable) begin
          state_d   = ST_DCA_FETCH;
          addr_d    = dca_ptr_q;
          dca_cnt_d = '0;
        end
      end
      ST_ICA_FETCH, ST_DCA_FETCH: begin
        if (field_start) begin
          ica_ptr_d = ICA_START;
          if (mem_req && !mem_ack) begin
            state_d = ST_DRAIN;  // outstanding read: hold the address until it completes
          end else begin
            // Either nothing outstanding or the read completes now; its data is dropped.
            state_d   = ST_ICA_FETCH;
            addr_d    = ICA_START;
            req_gap_d = ack_v;
          end
        end else if (ack_v) begin
          if (state_q == ST_ICA_FETCH) begin
            ica_ptr_d = ica_ptr_q + 23'd4;
            state_d   = ST_ICA_EXEC;
          end else begin
            dca_ptr_d = dca_ptr_q + 23'd4;
            dca_cnt_d = dca_cnt_q + CNT_W'(1);
            state_d   = ST_DCA_EXEC;
          end
          stop_d = dec_stop;
          // Pointer reloads override the increment above.
          case (dec_op)
            OP_LD_DCP, OP_LD_DCP_STP: dca_ptr_d = dec_ptr;
            OP_LD_ICA:                ica_ptr_d = dec_ptr;
            OP_LD_VSR_STP:            vsr_d     = dec_vsr;
            OP_IRQ:                   irq_d     = 1'b1;
            OP_PARAMS:                params_d  = dec_params;
            default: begin
              if (dec_reg_write) begin
                reg_we_d   = 1'b1;
                reg_addr_d = dec_reg_addr;
                reg_data_d = dec_reg_data;
              end
            end
          endcase
        end
      end
      ST_ICA_EXEC, ST_DCA_EXEC: begin
        if (field_start) begin
          state_d   = ST_ICA_FETCH;
          ica_ptr_d = ICA_START;
          addr_d    = ICA_START;
        end else if (stop_q || ((state_q == ST_DCA_EXEC) && (dca_cnt_q == DCA_LIMIT))) begin
          state_d = ST_WAIT_LINE;
        end else if (state_q == ST_ICA_EXEC) begin
          state_d = ST_ICA_FETCH;
          addr_d  = ica_ptr_q;
        end else begin
          state_d = ST_DCA_FETCH;
          addr_d  = dca_ptr_q;
        end
      end
      ST_DRAIN: begin
        ica_ptr_d = ICA_START;
        if (ack_v) begin
          state_d   = ST_ICA_FETCH;
          addr_d    = ICA_START;
          req_gap_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      ica_ptr_q  <= ICA_START;
      dca_ptr_q  <= '0;
      addr_q     <= ICA_START;
      dca_cnt_q  <= '0;
      stop_q     <= 1'b0;
      req_gap_q  <= 1'b0;
      reg_we_q   <= 1'b0;
      reg_addr_q <= '0;
      reg_data_q <= '0;
      vsr_q      <= '0;
      params_q   <= '0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ica_ptr_q  <= ica_ptr_d;
      dca_ptr_q  <= dca_ptr_d;
      addr_q     <= addr_d;
      dca_cnt_q  <= dca_cnt_d;
      stop_q     <= stop_d;
      req_gap_q  <= req_gap_d;
      reg_we_q   <= reg_we_d;
      reg_addr_q <= reg_addr_d;
      reg_data_q <= reg_data_d;
      vsr_q      <= vsr_d;
      params_q   <= params_d;
      irq_q      <= irq_d;
    end
  end

  assign mem_addr    = addr_q;
  assign reg_we      = reg_we_q;
  assign reg_addr    = reg_addr_q;
  assign reg_data    = reg_data_q;
  assign vsr_ptr     = vsr_q;
  assign disp_params = params_q;
  assign irq         = irq_q;
  assign busy        = (state_q != ST_IDLE) && (state_q != ST_WAIT_LINE);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_display_control_sequencer.sv
// Bench for display_control_sequencer: memory responder, register-write
// and read-address scoreboards, a vector table for single instructions and
// hand-written sequences for the multi-cycle cases.
module tb_display_control_sequencer;
  import display_control_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        field_start, line_start, dca_enable;
  logic        mem_req, mem_ack;
  logic [22:0] mem_addr;
  logic [31:0] mem_data;
  logic        reg_we, irq, busy;
  logic [6:0]  reg_addr;
  logic [23:0] reg_data;
  logic [22:0] vsr_ptr;
  logic [4:0]  disp_params;
  logic [2:0]  dbg_state;

  display_control_sequencer dut (
    .clk(clk), .reset_n(reset_n), .field_start(field_start), .line_start(line_start),
    .dca_enable(dca_enable), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_data(mem_data), .reg_we(reg_we), .reg_addr(reg_addr), .reg_data(reg_data),
    .vsr_ptr(vsr_ptr), .disp_params(disp_params), .irq(irq), .busy(busy),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int irq_seen = 0;
  logic        hold_ack = 1'b0;
  logic [31:0] mem [0:4095];
  logic [22:0] exp_rd_q[$];
  logic [30:0] exp_reg_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------- memory responder / read scoreboard ----------------
  initial begin
    mem_ack  = 1'b0;
    mem_data = '0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (mem_req && !hold_ack && reset_n) begin
        mem_ack  = 1'b1;
        mem_data = mem[mem_addr[13:2]];
        if (exp_rd_q.size() == 0) begin
          n_checks++;
          $display("FAIL rd_unexpected: got read 0x%0h expected none", mem_addr);
        end else begin
          check("rd_addr", 32'(mem_addr), 32'(exp_rd_q.pop_front()));
        end
      end
    end
  end

  // ---------------- output monitor / register-write scoreboard ----------------
  always @(negedge clk) begin
    if (reset_n && reg_we) begin
      if (exp_reg_q.size() == 0) begin
        n_checks++;
        $display("FAIL reg_we_unexpected: got 0x%0h/0x%0h expected none", reg_addr, reg_data);
      end else begin
        check("reg_write", 32'({reg_addr, reg_data}), 32'(exp_reg_q.pop_front()));
      end
    end
    if (reset_n && irq) irq_seen++;
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_field();
    @(negedge clk) field_start = 1'b1;
    @(negedge clk) field_start = 1'b0;
  endtask

  task automatic pulse_line();
    @(negedge clk) line_start = 1'b1;
    @(negedge clk) line_start = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget, input string name);
    for (int k = 0; k < budget; k++) begin
      if (dbg_state == st) break;
      @(negedge clk);
    end
    check(name, 32'(dbg_state), 32'(st));
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
  endtask

  task automatic check_drained(input string name);
    check({name, "_rd_left"}, 32'(exp_rd_q.size()), 32'd0);
    check({name, "_reg_left"}, 32'(exp_reg_q.size()), 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] instr;
    bit          reg_wr;
    bit          stop;
    logic [6:0]  r_addr;
    logic [23:0] r_data;
    logic [22:0] vsr;
    logic [4:0]  params;
    int          irqs;
  } vec_t;

  vec_t vecs[9];

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    reset_n = 1'b0; field_start = 1'b0; line_start = 1'b0; dca_enable = 1'b0;
    clear_mem();
    vecs[0] = '{32'h8A123456, 1, 0, 7'h0A, 24'h123456, 23'h0,      5'h00, 0};
    vecs[1] = '{32'hFFABCDEF, 1, 0, 7'h7F, 24'hABCDEF, 23'h0,      5'h00, 0};
    vecs[2] = '{32'h80000001, 1, 0, 7'h00, 24'h000001, 23'h0,      5'h00, 0};
    vecs[3] = '{32'h7000001F, 0, 0, 7'h00, 24'h0,      23'h0,      5'h1F, 0};
    vecs[4] = '{32'h70000005, 0, 0, 7'h00, 24'h0,      23'h0,      5'h05, 0};
    vecs[5] = '{32'h507FFFFF, 0, 1, 7'h00, 24'h0,      23'h7FFFFE, 5'h05, 0};
    vecs[6] = '{32'h60000000, 0, 0, 7'h00, 24'h0,      23'h7FFFFE, 5'h05, 1};
    vecs[7] = '{32'h10000000, 0, 0, 7'h00, 24'h0,      23'h7FFFFE, 5'h05, 0};
    vecs[8] = '{32'h50000003, 0, 1, 7'h00, 24'h0,      23'h000002, 5'h05, 0};

    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'h400);
    check("rst_reg_we", 32'(reg_we), 32'd0);
    check("rst_reg_addr", 32'(reg_addr), 32'd0);
    check("rst_reg_data", 32'(reg_data), 32'd0);
    check("rst_vsr", 32'(vsr_ptr), 32'd0);
    check("rst_params", 32'(disp_params), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // Single-instruction ICA programs, each followed by a stop word.
    for (int v = 0; v < 9; v++) begin
      mem[32'h400 >> 2] = vecs[v].instr;
      mem[32'h404 >> 2] = 32'h0;
      irq_seen = 0;
      exp_rd_q.push_back(23'h400);
      if (!vecs[v].stop) exp_rd_q.push_back(23'h404);
      if (vecs[v].reg_wr) exp_reg_q.push_back({vecs[v].r_addr, vecs[v].r_data});
      pulse_field();
      wait_state(ST_WAIT_LINE, 50, "vec_wait_line");
      check("vec_vsr", 32'(vsr_ptr), 32'(vecs[v].vsr));
      check("vec_params", 32'(disp_params), 32'(vecs[v].params));
      check("vec_irq_cycles", 32'(irq_seen), 32'(vecs[v].irqs));
      check("vec_busy", 32'(busy), 32'd0);
      check_drained("vec");
    end

    // Reload DCP, set VSR+stop; DCA then starts at the reloaded pointer.
    mem[32'h400 >> 2] = 32'h20001000;
    mem[32'h404 >> 2] = 32'h50002000;
    mem[32'h1000 >> 2] = 32'h0;
    exp_rd_q.push_back(23'h400);
    exp_rd_q.push_back(23'h404);
    pulse_field();
    wait_state(ST_WAIT_LINE, 50, "t2_ica_done");
    check("t2_vsr", 32'(vsr_ptr), 32'h002000);
    dca_enable = 1'b1;
    exp_rd_q.push_back(23'h1000);
    pulse_line();
    wait_state(ST_WAIT_LINE, 50, "t2_dca_done");
    check_drained("t2");

    // DCA of 20 nops is cut at 16 and resumes on the next line.
    mem[32'h400 >> 2] = 32'h30001000;
    for (int i = 0; i < 20; i++) mem[(32'h1000 >> 2) + i] = 32'h10000000;
    mem[32'h1050 >> 2] = 32'h0;
    exp_rd_q.push_back(23'h400);
    pulse_field();
    wait_state(ST_WAIT_LINE, 50, "t3_ica_done");
    for (int i = 0; i < 16; i++) exp_rd_q.push_back(23'(32'h1000 + 4 * i));
    pulse_line();
    wait_state(ST_WAIT_LINE, 200, "t3_line1_done");
    check_drained("t3_line1");
    for (int i = 16; i < 21; i++) exp_rd_q.push_back(23'(32'h1000 + 4 * i));
    pulse_line();
    wait_state(ST_WAIT_LINE, 200, "t3_line2_done");
    check_drained("t3_line2");

    // field_start while a read is held off: DRAIN keeps the request, discards data.
    mem[32'h400 >> 2] = 32'h8A123456;
    mem[32'h404 >> 2] = 32'h0;
    hold_ack = 1'b1;
    pulse_field();
    @(negedge clk);
    check("t4_req_pending", 32'(mem_req), 32'd1);
    pulse_field();
    for (int i = 0; i < 5; i++) begin
      check("t4_drain_req", 32'(mem_req), 32'd1);
      check("t4_drain_addr", 32'(mem_addr), 32'h400);
      @(negedge clk);
    end
    check("t4_drain_state", 32'(dbg_state), 32'(ST_DRAIN));
    check("t4_drain_busy", 32'(busy), 32'd1);
    exp_rd_q.push_back(23'h400);
    hold_ack = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_ack) break;
    end
    check("t4_ack_seen", 32'(mem_ack), 32'd1);
    hold_ack = 1'b1;
    mem[32'h400 >> 2] = 32'h0;
    @(negedge clk);
    check("t4_refetch_state", 32'(dbg_state), 32'(ST_ICA_FETCH));
    check("t4_refetch_addr", 32'(mem_addr), 32'h400);
    check("t4_req_gap", 32'(mem_req), 32'd0);
    exp_rd_q.push_back(23'h400);
    hold_ack = 1'b0;
    wait_state(ST_WAIT_LINE, 50, "t4_done");
    check_drained("t4");

    // irq, ICA pointer reload, display parameters.
    mem[32'h400 >> 2] = 32'h60000000;
    mem[32'h404 >> 2] = 32'h40000800;
    mem[32'h408 >> 2] = 32'h7000001F;
    mem[32'h800 >> 2] = 32'h7000001F;
    mem[32'h804 >> 2] = 32'h0;
    irq_seen = 0;
    exp_rd_q.push_back(23'h400);
    exp_rd_q.push_back(23'h404);
    exp_rd_q.push_back(23'h800);
    exp_rd_q.push_back(23'h804);
    pulse_field();
    wait_state(ST_WAIT_LINE, 60, "t5_done");
    check("t5_irq_cycles", 32'(irq_seen), 32'd1);
    check("t5_params", 32'(disp_params), 32'h1F);
    check_drained("t5");

    // line_start during ICA is dropped; dca_enable=0 suppresses DCA.
    for (int i = 0; i < 4; i++) mem[(32'h400 >> 2) + i] = 32'h10000000;
    mem[32'h410 >> 2] = 32'h0;
    for (int i = 0; i < 5; i++) exp_rd_q.push_back(23'(32'h400 + 4 * i));
    pulse_field();
    pulse_line();
    wait_state(ST_WAIT_LINE, 60, "t6_ica_done");
    repeat (4) @(negedge clk);
    check("t6_no_dca_state", 32'(dbg_state), 32'(ST_WAIT_LINE));
    check_drained("t6_ica");
    dca_enable = 1'b0;
    pulse_line();
    repeat (5) @(negedge clk);
    check("t6_disabled_state", 32'(dbg_state), 32'(ST_WAIT_LINE));
    check("t6_disabled_req", 32'(mem_req), 32'd0);

    // Asynchronous reset in the middle of a fetch.
    hold_ack = 1'b1;
    pulse_field();
    @(negedge clk);
    check("t6_req_before_rst", 32'(mem_req), 32'd1);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("arst_mem_req", 32'(mem_req), 32'd0);
    check("arst_mem_addr", 32'(mem_addr), 32'h400);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_vsr", 32'(vsr_ptr), 32'd0);
    check("arst_params", 32'(disp_params), 32'd0);
    check("arst_reg_data", 32'(reg_data), 32'd0);
    check("arst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    reset_n  = 1'b1;
    hold_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check_drained("final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
